// File: rtl/mmu_sram_responder.sv
// mmu_sram_responder
//   Memory-side responder for the CPU-to-MMU word bus. Translates kseg0/kseg1
//   virtual addresses to physical, checks range and write protection, and runs
//   one 32-bit access on an asynchronous SRAM with WAIT_CYCLES-long strobes.
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   ce_i, we_i           request valid, 1 = write
//   addr_i, data_i       virtual byte address, write data
//   ready_o              one-cycle completion pulse
//   data_o               read data (0 for writes/errors), held until next completion
//   tlb_err_o, mod_o     completion flags, held until next completion
//   sram_*               SRAM address/data/strobes, all registered
module mmu_sram_responder #(
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 20,
    parameter logic [31:0] PROT_LIMIT  = 32'h0000_1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic               ready_o,
    output logic [31:0]        data_o,
    output logic               tlb_err_o,
    output logic               mod_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_dq_o,
    input  logic [31:0]        sram_dq_i,
    output logic               sram_dq_oe_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ERR, DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam int         RANGE_LO  = SRAM_AW + 2;

    state_t      state, nxt;
    logic [3:0]  cnt;
    logic        req_tlb, req_mod;

    logic [31:0] pa;
    logic        seg_ok, acc_tlb, acc_mod, accept;

    // Request decode, only meaningful on the acceptance edge.
    always_comb begin
        pa      = {3'b000, addr_i[28:0]};
        seg_ok  = (addr_i[31:29] == 3'b100) || (addr_i[31:29] == 3'b101);
        acc_tlb = !seg_ok || (pa[28:RANGE_LO] != '0);
        acc_mod = !acc_tlb && we_i && (pa < PROT_LIMIT);
        accept  = (state == IDLE) && ce_i;
    end

    // DONE always returns to IDLE, so a held ce_i is taken on the edge that
    // ends the following IDLE cycle.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (ce_i) nxt = (acc_tlb || acc_mod) ? ERR : (we_i ? WR_SETUP : RD);
            RD:       if (cnt == 4'd0) nxt = DONE;
            WR_SETUP: nxt = WR_PULSE;
            WR_PULSE: if (cnt == 4'd0) nxt = WR_HOLD;
            WR_HOLD:  nxt = DONE;
            ERR:      nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Strobes are registered from the next state so each one lines up
    // exactly with the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= 4'd0;
            req_tlb      <= 1'b0;
            req_mod      <= 1'b0;
            ready_o      <= 1'b0;
            data_o       <= 32'd0;
            tlb_err_o    <= 1'b0;
            mod_o        <= 1'b0;
            sram_addr_o  <= '0;
            sram_dq_o    <= 32'd0;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
        end else begin
            if (accept) begin
                req_tlb <= acc_tlb;
                req_mod <= acc_mod;
                if (!acc_tlb && !acc_mod) begin
                    sram_addr_o <= pa[SRAM_AW+1:2];
                    sram_dq_o   <= data_i;
                end
            end

            if ((nxt == RD && state != RD) || (nxt == WR_PULSE && state != WR_PULSE))
                cnt <= WAIT_LOAD;
            else if ((state == RD || state == WR_PULSE) && cnt != 4'd0)
                cnt <= cnt - 4'd1;

            ready_o      <= (nxt == DONE);
            sram_ce_n_o  <= !(nxt inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
            sram_oe_n_o  <= !(nxt == RD);
            sram_we_n_o  <= !(nxt == WR_PULSE);
            sram_dq_oe_o <= (nxt inside {WR_SETUP, WR_PULSE, WR_HOLD});

            // Entry to DONE: publish the result; a clean completion clears the flags.
            if (nxt == DONE && state != DONE) begin
                tlb_err_o <= req_tlb;
                mod_o     <= req_mod;
                data_o    <= (state == RD) ? sram_dq_i : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_sram_responder.sv
// tb_mmu_sram_responder
//   Three responders (WAIT_CYCLES 2, 1, 15) share the request bus; only the
//   selected one sees ce. A transaction-level model predicts completions,
//   flags, read data and SRAM strobe windows; one process compares every cycle.
module tb_mmu_sram_responder;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic ce, we;
    logic [31:0] addr, wdata;
    int cur;

    logic [NI-1:0]        ce_v, ready_v, tlb_v, mod_v, dq_oe_v, ce_n_v, oe_n_v, we_n_v;
    logic [NI-1:0][31:0]  dout_v, sdq_o_v;
    logic [NI-1:0][19:0]  saddr_v;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] sram    [int];
    logic [31:0] exp_mem [int];

    always #5 clk = ~clk;

    function automatic int wc_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 15;
    endfunction

    function automatic logic [31:0] dflt(input int key);
        return 32'hA500_0000 + 32'(key);
    endfunction

    function automatic logic [31:0] sram_rd(input int key);
        return sram.exists(key) ? sram[key] : dflt(key);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        logic [31:0] rd_val;

        assign ce_v[g] = ce && (cur == g);

        always_comb begin
            rd_val = 32'h0BAD_0BAD;
            if (!ce_n_v[g] && !oe_n_v[g]) rd_val = sram_rd(g * (1 << 20) + int'(saddr_v[g]));
        end

        // Asynchronous SRAM commits on the rising edge of we_n.
        always @(posedge we_n_v[g])
            if (rst_n && !ce_n_v[g] && dq_oe_v[g]) sram[g * (1 << 20) + int'(saddr_v[g])] = sdq_o_v[g];

        mmu_sram_responder #(.WAIT_CYCLES(W), .SRAM_AW(20), .PROT_LIMIT(32'h0000_1000)) u_dut (
            .clk(clk), .rst(rst_n), .ce_i(ce_v[g]), .we_i(we), .addr_i(addr), .data_i(wdata),
            .ready_o(ready_v[g]), .data_o(dout_v[g]), .tlb_err_o(tlb_v[g]), .mod_o(mod_v[g]),
            .sram_addr_o(saddr_v[g]), .sram_dq_o(sdq_o_v[g]), .sram_dq_i(rd_val),
            .sram_dq_oe_o(dq_oe_v[g]), .sram_ce_n_o(ce_n_v[g]), .sram_oe_n_o(oe_n_v[g]),
            .sram_we_n_o(we_n_v[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          redge;
        logic        wr;
        int          key;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        tlb;
        logic        md;
    } cpl_t;

    cpl_t q[$];
    int edge_n = 0;
    int next_acc;
    int ce_lo, ce_hi, oe_lo, oe_hi, we_lo, we_hi, dq_lo, dq_hi;
    logic [19:0] x_saddr;
    logic [31:0] x_sdq, x_data;
    logic x_ready, x_tlb, x_mod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            next_acc = 0;
            ce_lo = 0; ce_hi = -1; oe_lo = 0; oe_hi = -1;
            we_lo = 0; we_hi = -1; dq_lo = 0; dq_hi = -1;
            x_ready = 0; x_data = 0; x_tlb = 0; x_mod = 0;
            x_saddr = 0; x_sdq = 0;
        end else begin
            edge_n++;
            x_ready = 0;
            if (q.size() > 0 && q[0].redge == edge_n) begin
                x_ready = 1;
                x_tlb   = q[0].tlb;
                x_mod   = q[0].md;
                x_data  = q[0].rd;
                if (q[0].wr && !q[0].tlb && !q[0].md) exp_mem[q[0].key] = q[0].wd;
                void'(q.pop_front());
            end
            if (edge_n >= next_acc && ce) begin
                int unsigned pa, seg;
                int w, lat;
                cpl_t c;
                w   = wc_of(cur);
                seg = addr >> 29;
                pa  = addr & 32'h1FFF_FFFC;
                c.wr  = we;
                c.tlb = !(seg == 4 || seg == 5) || pa >= 32'h0040_0000;
                c.md  = !c.tlb && we && pa < 32'h0000_1000;
                c.key = cur * (1 << 20) + int'(pa >> 2);
                c.wd  = wdata;
                c.rd  = 0;
                ce_lo = 0; ce_hi = -1; oe_lo = 0; oe_hi = -1;
                we_lo = 0; we_hi = -1; dq_lo = 0; dq_hi = -1;
                if (c.tlb || c.md) lat = 2;
                else if (we) begin
                    lat = w + 3;
                    dq_lo = edge_n; dq_hi = edge_n + w + 1;
                    we_lo = edge_n + 1; we_hi = edge_n + w;
                end else begin
                    lat = w + 1;
                    oe_lo = edge_n; oe_hi = edge_n + w - 1;
                    c.rd = exp_mem.exists(c.key) ? exp_mem[c.key] : dflt(c.key);
                end
                if (!(c.tlb || c.md)) begin
                    ce_lo = edge_n; ce_hi = edge_n + lat - 2;
                    x_saddr = 20'(pa >> 2);
                    x_sdq   = wdata;
                end
                c.redge  = edge_n + lat - 1;
                next_acc = edge_n + lat + 1;
                q.push_back(c);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int   we_run = 0;
    logic we_low_seen = 0;

    always @(negedge clk) begin
        logic ce_x, oe_x, we_x, dq_x;
        ce_x = edge_n >= ce_lo && edge_n <= ce_hi;
        oe_x = edge_n >= oe_lo && edge_n <= oe_hi;
        we_x = edge_n >= we_lo && edge_n <= we_hi;
        dq_x = edge_n >= dq_lo && edge_n <= dq_hi;
        chk("ready_o", 32'(ready_v[cur]), 32'(x_ready));
        chk("data_o", dout_v[cur], x_data);
        chk("tlb_err_o", 32'(tlb_v[cur]), 32'(x_tlb));
        chk("mod_o", 32'(mod_v[cur]), 32'(x_mod));
        chk("sram_ce_n", 32'(ce_n_v[cur]), 32'(!ce_x));
        chk("sram_oe_n", 32'(oe_n_v[cur]), 32'(!oe_x));
        chk("sram_we_n", 32'(we_n_v[cur]), 32'(!we_x));
        chk("sram_dq_oe", 32'(dq_oe_v[cur]), 32'(dq_x));
        if (ce_x) chk("sram_addr", 32'(saddr_v[cur]), 32'(x_saddr));
        if (dq_x) chk("sram_dq", sdq_o_v[cur], x_sdq);
        if (!we_n_v[cur]) we_low_seen = 1;
        if (!rst_n) we_run = 0;
        else if (!we_n_v[cur]) we_run++;
        else if (we_run > 0) begin
            chk("we_n pulse width", 32'(we_run), 32'(wc_of(cur)));
            we_run = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        ce = 1; we = w; addr = a; wdata = d;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready_v[cur]) break;
        end
        if (!ready_v[cur]) chk("request timeout", 32'(ready_v[cur]), 32'd1);
        ce = 0;
    endtask

    task automatic sw(input int i);
        @(negedge clk);
        ce = 0;
        #2 rst_n = 0;
        @(negedge clk);
        cur = i;
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [31:0] pool(input int k);
        case (k)
            0: return 32'h8000_2000;  1: return 32'h8000_2004;
            2: return 32'hA000_2008;  3: return 32'h8000_200C;
            4: return 32'hA000_2000;  5: return 32'h8000_0100;
            6: return 32'h0040_0000;  7: return 32'h8FFF_FFFC;
            8: return 32'hC000_0000;  9: return 32'h803F_FFFC;
            10: return 32'h8040_0000; 11: return 32'h8000_0FFC;
            12: return 32'h8000_1000; default: return 32'hA03F_FFFC;
        endcase
    endfunction

    task automatic rand_phase(input int ncyc, input int hold);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            ce    = (i < hold) ? 1'b1 : ($urandom_range(0, 7) != 0);
            we    = 1'($urandom_range(0, 1));
            addr  = pool($urandom_range(0, 13)) | 32'($urandom_range(0, 3));
            wdata = $urandom;
        end
        @(negedge clk);
        ce = 0;
        repeat (24) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        ce = 0; we = 0; addr = 0; wdata = 0; cur = 0; rst_n = 1;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset ready_o", 32'(ready_v[0]), 32'd0);
        chk("reset sram_ce_n", 32'(ce_n_v[0]), 32'd1);
        chk("reset sram_we_n", 32'(we_n_v[0]), 32'd1);
        chk("reset data_o", dout_v[0], 32'd0);
        rst_n = 1;

        // write then read through the kseg1 alias
        do_req(1, 32'h8000_2000, 32'hDEAD_BEEF, lat);
        chk("t1 write latency", 32'(lat), 32'd5);
        chk("t1 write flags", {30'd0, tlb_v[0], mod_v[0]}, 32'd0);
        do_req(0, 32'hA000_2000, 32'd0, lat);
        chk("t1 read latency", 32'(lat), 32'd3);
        chk("t1 read data", dout_v[0], 32'hDEAD_BEEF);

        // protected write is dropped
        we_low_seen = 0;
        do_req(1, 32'h8000_0100, 32'h1111_2222, lat);
        chk("t2 mod latency", 32'(lat), 32'd2);
        chk("t2 mod_o", 32'(mod_v[0]), 32'd1);
        chk("t2 we_n untouched", 32'(we_low_seen), 32'd0);
        do_req(0, 32'h8000_0100, 32'd0, lat);
        chk("t2 old value", dout_v[0], 32'hA500_0040);
        chk("t2 mod cleared", 32'(mod_v[0]), 32'd0);

        // unmapped and out-of-range reads
        do_req(0, 32'h0040_0000, 32'd0, lat);
        chk("t3 kuseg tlb_err", 32'(tlb_v[0]), 32'd1);
        chk("t3 kuseg data", dout_v[0], 32'd0);
        do_req(0, 32'h8FFF_FFFC, 32'd0, lat);
        chk("t3 range tlb_err", 32'(tlb_v[0]), 32'd1);
        chk("t3 range latency", 32'(lat), 32'd2);

        // reset in the second WR_PULSE cycle
        @(negedge clk);
        ce = 1; we = 1; addr = 32'h8000_3000; wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        ce = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("t5 we_n after reset", 32'(we_n_v[0]), 32'd1);
        chk("t5 dq_oe after reset", 32'(dq_oe_v[0]), 32'd0);
        chk("t5 ready after reset", 32'(ready_v[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        do_req(0, 32'h8000_3000, 32'd0, lat);
        chk("t5 read latency", 32'(lat), 32'd3);
        chk("t5 aborted write", dout_v[0], 32'hA500_0C00);

        // wait-state sweep
        sw(1);
        do_req(1, 32'h8000_4000, 32'hCAFE_0001, lat);
        chk("t6 w1 write latency", 32'(lat), 32'd4);
        do_req(0, 32'h8000_4000, 32'd0, lat);
        chk("t6 w1 read latency", 32'(lat), 32'd2);
        chk("t6 w1 read data", dout_v[1], 32'hCAFE_0001);
        sw(2);
        do_req(1, 32'h8000_4000, 32'hCAFE_000F, lat);
        chk("t6 w15 write latency", 32'(lat), 32'd18);
        do_req(0, 32'h8000_4000, 32'd0, lat);
        chk("t6 w15 read latency", 32'(lat), 32'd16);
        chk("t6 w15 read data", dout_v[2], 32'hCAFE_000F);

        // randomized traffic, starting with ce held high
        sw(0);
        rand_phase(500, 150);
        sw(1);
        rand_phase(250, 80);
        sw(2);
        rand_phase(300, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
